// File: rtl/bus_share_arbiter_if.sv
// Requester-side and DUT-side signals of the shared register-port arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface bus_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  localparam int GID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wr_n;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         req_rdata;
  logic                      req_err;
  logic [GID_W-1:0]          grant_id;
  logic                      valid_o;
  logic                      wr_n_o;
  logic [ADDR_W-1:0]         addr_o;
  logic [DATA_W-1:0]         data_o;
  logic                      ready_i;
  logic [DATA_W-1:0]         data_i;

  modport master (
    input  req_valid, req_wr_n, req_addr, req_wdata, ready_i, data_i,
    output req_ready, req_rdata, req_err, grant_id, valid_o, wr_n_o, addr_o, data_o
  );

  modport slave (
    output req_valid, req_wr_n, req_addr, req_wdata, ready_i, data_i,
    input  req_ready, req_rdata, req_err, grant_id, valid_o, wr_n_o, addr_o, data_o
  );
endinterface

// File: rtl/bus_share_arbiter.sv
// Round-robin arbiter sharing one DUT register port between NUM_REQ requesters,
// with a bounded wait on the DUT handshake that ends in an error completion.
module bus_share_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input logic                 clk,
  input logic                 reset,
  bus_share_arbiter_if.master bus
);
  localparam int GID_W  = $clog2(NUM_REQ);
  localparam int WAIT_W = 8;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e             state_q;
  logic [GID_W-1:0]   last_grant_q;
  logic [GID_W-1:0]   grant_q;
  logic [WAIT_W-1:0]  wait_q;
  logic               valid_q;
  logic               wr_n_q;
  logic               err_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [NUM_REQ-1:0] ready_q;

  logic [GID_W-1:0]   grant_d;
  logic [GID_W-1:0]   cand;
  logic               pick_vld;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GID_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: first pending requester above the last one served, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    grant_d  = '0;
    cand     = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GID_W'((int'(last_grant_q) + off) % NUM_REQ);
      if (!pick_vld && bus.req_valid[cand]) begin
        pick_vld = 1'b1;
        grant_d  = cand;
      end else begin
        pick_vld = pick_vld;
      end
    end
  end

  // Transaction sequencer: arbitrate, drive the DUT handshake, report completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= GID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      wait_q       <= '0;
      valid_q      <= 1'b0;
      wr_n_q       <= 1'b1;
      err_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            grant_q <= grant_d;
            wr_n_q  <= bus.req_wr_n[grant_d];
            addr_q  <= bus.req_addr[int'(grant_d)*ADDR_W +: ADDR_W];
            data_q  <= bus.req_wdata[int'(grant_d)*DATA_W +: DATA_W];
            valid_q <= 1'b1;
            wait_q  <= '0;
            state_q <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (bus.ready_i) begin
            valid_q      <= 1'b0;
            rdata_q      <= wr_n_q ? bus.data_i : rdata_q;
            err_q        <= 1'b0;
            ready_q      <= onehot(grant_q);
            last_grant_q <= grant_q;
            state_q      <= S_RESP;
          end else if (wait_q == WAIT_LAST) begin
            // DUT never answered: complete with an error so the requester is not stuck.
            valid_q      <= 1'b0;
            err_q        <= 1'b1;
            ready_q      <= onehot(grant_q);
            last_grant_q <= grant_q;
            state_q      <= S_RESP;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_RESP: begin
          ready_q <= '0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.valid_o   = valid_q;
  assign bus.wr_n_o    = wr_n_q;
  assign bus.addr_o    = addr_q;
  assign bus.data_o    = data_q;
  assign bus.req_ready = ready_q;
  assign bus.req_rdata = rdata_q;
  assign bus.req_err   = err_q;
  assign bus.grant_id  = grant_q;
endmodule
